// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one registered-read ROM between an instruction-fetch
// port (r0) and a data-load port (r1), one transaction at a time.
// Optional build macro ROM_ARBITER_ROUND_ROBIN_EN: ties go to the port not
// granted last; without it port 0 always wins a tie.
module rom_arbiter #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int EXTRA = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    // port 0: instruction fetch
    input  logic                      r0_valid,
    output logic                      r0_ready,
    input  logic [AW:0]               r0_addr,
    input  logic [EXTRA-1:0]          r0_extra,
    input  logic [AW:0]               r0_lower,
    input  logic [AW:0]               r0_upper,
    output logic                      r0_rsp_valid,
    input  logic                      r0_rsp_ready,
    output logic [(2**EXTRA)*DW-1:0]  r0_rsp_data,
    output logic                      r0_rsp_error,
    // port 1: data load
    input  logic                      r1_valid,
    output logic                      r1_ready,
    input  logic [AW:0]               r1_addr,
    input  logic [EXTRA-1:0]          r1_extra,
    input  logic [AW:0]               r1_lower,
    input  logic [AW:0]               r1_upper,
    output logic                      r1_rsp_valid,
    input  logic                      r1_rsp_ready,
    output logic [(2**EXTRA)*DW-1:0]  r1_rsp_data,
    output logic                      r1_rsp_error,
    // ROM side
    output logic [AW:0]               rom_addr,
    output logic [EXTRA-1:0]          rom_extra,
    output logic [AW:0]               rom_lower,
    output logic [AW:0]               rom_upper,
    input  logic [(2**EXTRA)*DW-1:0]  rom_data,
    input  logic                      rom_error,
    output logic                      busy
);
    localparam int RW = (2**EXTRA)*DW;

    typedef enum logic [1:0] {IDLE, READ, CAPT, RESP} state_t;

    state_t              state, state_nxt;
    logic                gnt;       // port picked this cycle (0/1), meaningful in IDLE
    logic                own;       // port owning the in-flight transaction
    logic                acc;
    logic                rsp_rdy;
    logic [1:0][RW-1:0]  rsp_data_q;
    logic [1:0]          rsp_err_q;

`ifdef ROM_ARBITER_ROUND_ROBIN_EN
    logic last;                     // port granted on the most recent accept

    // remember last winner; reset to port 1 so port 0 takes the first tie
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last <= 1'b1;
        else if (acc) last <= gnt;
    end

    // tie goes away from the last winner, otherwise to whoever asks
    always_comb begin
        gnt = !r0_valid;
        if (r0_valid && r1_valid) gnt = !last;
    end
`else
    // fixed priority: port 1 only when port 0 is not asking
    always_comb begin
        gnt = !r0_valid;
    end
`endif

    // ready only while idle, and only toward the picked port
    always_comb begin
        r0_ready = 1'b0;
        r1_ready = 1'b0;
        if (state == IDLE) begin
            r0_ready = r0_valid && !gnt;
            r1_ready = r1_valid &&  gnt;
        end
    end

    assign acc     = r0_ready || r1_ready;
    assign rsp_rdy = own ? r1_rsp_ready : r0_rsp_ready;

    // next state: fixed READ/CAPT walk, RESP waits for the owner's rsp_ready
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (acc) state_nxt = READ;
            READ:    state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    if (rsp_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // state register; reset drops any in-flight transaction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // latch the winning request onto the ROM bus; held until the next accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            own       <= 1'b0;
            rom_addr  <= '0;
            rom_extra <= '0;
            rom_lower <= '0;
            rom_upper <= '0;
        end else if (acc) begin
            own       <= gnt;
            rom_addr  <= gnt ? r1_addr  : r0_addr;
            rom_extra <= gnt ? r1_extra : r0_extra;
            rom_lower <= gnt ? r1_lower : r0_lower;
            rom_upper <= gnt ? r1_upper : r0_upper;
        end
    end

    // capture ROM result into the owner's response slot at the end of CAPT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_data_q <= '0;
            rsp_err_q  <= '0;
        end else if (state == CAPT) begin
            rsp_data_q[own] <= rom_data;
            rsp_err_q[own]  <= rom_error;
        end
    end

    assign r0_rsp_data  = rsp_data_q[0];
    assign r1_rsp_data  = rsp_data_q[1];
    assign r0_rsp_error = rsp_err_q[0];
    assign r1_rsp_error = rsp_err_q[1];
    assign r0_rsp_valid = (state == RESP) && !own;
    assign r1_rsp_valid = (state == RESP) &&  own;
    assign busy         = (state != IDLE);

endmodule
